// File: rtl/sync_fifo_ram_rd_ctrl.sv
// rtl/sync_fifo_ram_rd_ctrl.sv - single-clock FIFO controller in front of a two-port ECC RAM wrapper
//
// Purpose:
//   Writes go straight to wrapper port A. Reads are prefetched through the
//   wrapper's RD_LATENCY-cycle read pipeline on port B into a small output
//   buffer. The buffer head is presented on a valid/ready interface together
//   with the per-word ECC single/double error flags.
//
// Ports:
//   clk, rst_n           clock (also both wrapper clocks), async active-low reset
//   wr_vld/wr_rdy/wr_data            producer write handshake
//   rd_vld/rd_rdy/rd_data            consumer read handshake
//   rd_serr/rd_derr                  ECC flags of the head word
//   fifo_cnt                         words held: RAM + in flight + buffer
//   ram_csa/ram_wea/ram_aa/ram_da    wrapper port A (write)
//   ram_csb/ram_reb/ram_ab           wrapper port B (read issue)
//   ram_qb/ram_serr/ram_derr         wrapper read return
//   err_clr, serr_cnt, derr_cnt      ECC error counters
//
// Optional feature macro: FIFO_ECC_ERR_CNT_EN
//   defined   : serr_cnt/derr_cnt count popped flagged words, saturating,
//               cleared by err_clr
//   undefined : serr_cnt = derr_cnt = 0, err_clr ignored
module sync_fifo_ram_rd_ctrl #(
   parameter int ADDR_WIDTH = 5,
   parameter int DATA_WIDTH = 140,
   parameter int RD_LATENCY = 2,
   parameter int BUF_DEPTH  = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  wr_vld,
   output logic                  wr_rdy,
   input  logic [DATA_WIDTH-1:0] wr_data,
   output logic                  rd_vld,
   input  logic                  rd_rdy,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  rd_serr,
   output logic                  rd_derr,
   output logic [ADDR_WIDTH+1:0] fifo_cnt,
   output logic                  ram_csa,
   output logic                  ram_wea,
   output logic [ADDR_WIDTH-1:0] ram_aa,
   output logic [DATA_WIDTH-1:0] ram_da,
   output logic                  ram_csb,
   output logic                  ram_reb,
   output logic [ADDR_WIDTH-1:0] ram_ab,
   input  logic [DATA_WIDTH-1:0] ram_qb,
   input  logic                  ram_serr,
   input  logic                  ram_derr,
   input  logic                  err_clr,
   output logic [15:0]           serr_cnt,
   output logic [15:0]           derr_cnt
);

   localparam int CW  = ADDR_WIDTH + 2;
   localparam int BPW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
   localparam int EW  = DATA_WIDTH + 2;

   logic [ADDR_WIDTH-1:0] r_wptr;
   logic [ADDR_WIDTH-1:0] r_rptr;
   logic [ADDR_WIDTH:0]   r_mem_cnt;
   logic [RD_LATENCY-1:0] r_rd_sr;
   logic [CW-1:0]         r_buf_cnt;
   logic [BPW-1:0]        r_head;
   logic [BPW-1:0]        r_tail;
   logic [EW-1:0]         r_buf [BUF_DEPTH];

   logic                  w_wr;
   logic                  w_iss;
   logic                  w_ret;
   logic                  w_pop;
   logic [CW-1:0]         w_inflight;
   logic [EW-1:0]         w_head;

   function automatic logic [BPW-1:0] f_bnext(input logic [BPW-1:0] p);
      return (p == BPW'(BUF_DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   // mem_cnt never exceeds DEPTH = 1<<ADDR_WIDTH, so its MSB alone marks full
   assign wr_rdy = ~r_mem_cnt[ADDR_WIDTH];
   assign w_wr   = wr_vld & wr_rdy;

   always_comb begin
      w_inflight = '0;
      for (int i = 0; i < RD_LATENCY; i++) begin
         w_inflight = w_inflight + CW'(r_rd_sr[i]);
      end
   end

   // Credit check: every in-flight read already owns a buffer slot, so the
   // buffer can never overflow when its return lands.
   assign w_iss = (r_mem_cnt != '0) && ((w_inflight + r_buf_cnt) < CW'(BUF_DEPTH));
   assign w_ret = r_rd_sr[RD_LATENCY-1];

   assign rd_vld  = (r_buf_cnt != '0);
   assign w_pop   = rd_vld & rd_rdy;
   assign w_head  = r_buf[r_head];
   assign rd_data = w_head[EW-1:2];
   assign rd_serr = w_head[1];
   assign rd_derr = w_head[0];

   assign fifo_cnt = CW'(r_mem_cnt) + w_inflight + r_buf_cnt;

   assign ram_csa = w_wr;
   assign ram_wea = w_wr;
   assign ram_aa  = r_wptr;
   assign ram_da  = w_wr ? wr_data : '0;
   assign ram_csb = w_iss;
   assign ram_reb = w_iss;
   assign ram_ab  = r_rptr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wptr    <= '0;
         r_rptr    <= '0;
         r_mem_cnt <= '0;
         r_rd_sr   <= '0;
         r_buf_cnt <= '0;
         r_head    <= '0;
         r_tail    <= '0;
         for (int i = 0; i < BUF_DEPTH; i++) begin
            r_buf[i] <= '0;
         end
      end else begin
         if (w_wr) begin
            r_wptr <= r_wptr + 1'b1;
         end
         if (w_iss) begin
            r_rptr <= r_rptr + 1'b1;
         end
         if (w_wr && !w_iss) begin
            r_mem_cnt <= r_mem_cnt + 1'b1;
         end else if (!w_wr && w_iss) begin
            r_mem_cnt <= r_mem_cnt - 1'b1;
         end
         // Valid bit rides alongside the wrapper's read pipeline
         r_rd_sr <= (r_rd_sr << 1) | RD_LATENCY'(w_iss);
         if (w_ret) begin
            r_buf[r_tail] <= {ram_qb, ram_serr, ram_derr};
            r_tail        <= f_bnext(r_tail);
         end
         if (w_pop) begin
            r_head <= f_bnext(r_head);
         end
         if (w_ret && !w_pop) begin
            r_buf_cnt <= r_buf_cnt + 1'b1;
         end else if (!w_ret && w_pop) begin
            r_buf_cnt <= r_buf_cnt - 1'b1;
         end
      end
   end

`ifdef FIFO_ECC_ERR_CNT_EN
   logic [15:0] r_serr_cnt;
   logic [15:0] r_derr_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_serr_cnt <= '0;
         r_derr_cnt <= '0;
      end else if (err_clr) begin
         r_serr_cnt <= '0;
         r_derr_cnt <= '0;
      end else if (w_pop) begin
         if (rd_serr && (r_serr_cnt != 16'hFFFF)) begin
            r_serr_cnt <= r_serr_cnt + 1'b1;
         end
         if (rd_derr && (r_derr_cnt != 16'hFFFF)) begin
            r_derr_cnt <= r_derr_cnt + 1'b1;
         end
      end
   end

   assign serr_cnt = r_serr_cnt;
   assign derr_cnt = r_derr_cnt;
`else
   logic w_unused_err_clr;
   assign w_unused_err_clr = err_clr;
   assign serr_cnt = '0;
   assign derr_cnt = '0;
`endif

endmodule

// File: tb/tb_sync_fifo_ram_rd_ctrl.sv
// tb/tb_sync_fifo_ram_rd_ctrl.sv - self-checking bench for sync_fifo_ram_rd_ctrl with a 2-cycle ECC RAM wrapper model
`timescale 1ns/1ps
module tb_sync_fifo_ram_rd_ctrl;

   localparam int AW    = 5;
   localparam int DW    = 140;
   localparam int DEPTH = 1 << AW;

   typedef logic [159:0] v_t;

   logic           clk = 1'b0;
   logic           rst_n;
   logic           wr_vld;
   logic           wr_rdy;
   logic [DW-1:0]  wr_data;
   logic           rd_vld;
   logic           rd_rdy;
   logic [DW-1:0]  rd_data;
   logic           rd_serr;
   logic           rd_derr;
   logic [AW+1:0]  fifo_cnt;
   logic           ram_csa;
   logic           ram_wea;
   logic [AW-1:0]  ram_aa;
   logic [DW-1:0]  ram_da;
   logic           ram_csb;
   logic           ram_reb;
   logic [AW-1:0]  ram_ab;
   logic [DW-1:0]  ram_qb;
   logic           ram_serr;
   logic           ram_derr;
   logic           err_clr;
   logic [15:0]    serr_cnt;
   logic [15:0]    derr_cnt;

   always #5 clk = ~clk;

   sync_fifo_ram_rd_ctrl #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(2), .BUF_DEPTH(4)
   ) u_dut (
      .clk(clk), .rst_n(rst_n),
      .wr_vld(wr_vld), .wr_rdy(wr_rdy), .wr_data(wr_data),
      .rd_vld(rd_vld), .rd_rdy(rd_rdy), .rd_data(rd_data),
      .rd_serr(rd_serr), .rd_derr(rd_derr), .fifo_cnt(fifo_cnt),
      .ram_csa(ram_csa), .ram_wea(ram_wea), .ram_aa(ram_aa), .ram_da(ram_da),
      .ram_csb(ram_csb), .ram_reb(ram_reb), .ram_ab(ram_ab),
      .ram_qb(ram_qb), .ram_serr(ram_serr), .ram_derr(ram_derr),
      .err_clr(err_clr), .serr_cnt(serr_cnt), .derr_cnt(derr_cnt)
   );

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string tag, input v_t act, input v_t exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   function automatic logic [DW-1:0] pat(input int n);
      return {12'hA5C, n, ~n, n ^ 32'h5A5A_5A5A, n + 32'h1234};
   endfunction

   // Wrapper model: 2-cycle read pipeline; flags the 3rd and 7th reads since reset when err_en
   logic          err_en;
   logic [DW-1:0] mem [DEPTH];
   logic [DW+1:0] p1, p2;
   int            iss_idx = 0;

   always @(posedge clk) begin
      if (ram_csa && ram_wea) mem[ram_aa] <= ram_da;
      p1 <= {mem[ram_ab], err_en && (iss_idx == 2), err_en && (iss_idx == 6)};
      p2 <= p1;
      if (!rst_n) iss_idx <= 0;
      else if (ram_csb && ram_reb) iss_idx <= iss_idx + 1;
   end
   assign {ram_qb, ram_serr, ram_derr} = p2;

   // Monitor / scoreboard
   logic [DW-1:0] exp_q[$];
   int            pop_idx = 0;
   int            outst = 0;
   int            pops = 0;
   int            iss_total = 0;
   logic          hold = 1'b0;
   logic [DW-1:0] hold_d;
   logic [1:0]    hold_f;

   initial forever begin
      @(negedge clk);
      if (!rst_n) begin
         exp_q.delete();
         pop_idx = 0;
         outst   = 0;
         hold    = 1'b0;
      end else begin
         if (hold) begin
            chk("hold_data", v_t'(rd_data), v_t'(hold_d));
            chk("hold_flags", v_t'({rd_serr, rd_derr}), v_t'(hold_f));
         end
         if (rd_vld && rd_rdy) begin
            if (exp_q.size() == 0) chk("pop_empty", v_t'(1'b1), v_t'(1'b0));
            else chk("rd_data", v_t'(rd_data), v_t'(exp_q.pop_front()));
            chk("rd_serr", v_t'(rd_serr), v_t'(err_en && (pop_idx == 2)));
            chk("rd_derr", v_t'(rd_derr), v_t'(err_en && (pop_idx == 6)));
            pop_idx++;
            pops++;
            outst--;
         end
         if (wr_vld && wr_rdy) exp_q.push_back(wr_data);
         if (ram_csb) begin
            outst++;
            iss_total++;
            chk("buf_occ", v_t'(outst <= 4), v_t'(1'b1));
         end
         hold   = rd_vld && !rd_rdy;
         hold_d = rd_data;
         hold_f = {rd_serr, rd_derr};
      end
   end

   int wseq = 0;

   task automatic tick();
      logic acc;
      #3;
      acc = wr_vld && wr_rdy;
      @(posedge clk);
      #1;
      if (acc) begin
         wseq++;
         wr_data = pat(wseq);
      end
   endtask

   task automatic drain(input string tag);
      int n = 0;
      wr_vld = 1'b0;
      rd_rdy = 1'b1;
      while (fifo_cnt != 0 && n < 200) begin
         tick();
         n++;
      end
      chk(tag, v_t'(fifo_cnt), v_t'(0));
      chk({tag, "_q"}, v_t'(exp_q.size()), v_t'(0));
   endtask

   task automatic do_reset();
      rst_n  = 1'b0;
      wr_vld = 1'b0;
      rd_rdy = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   task automatic chk_reset_outs(input string tag);
      chk({tag, "_wr_rdy"}, v_t'(wr_rdy), v_t'(1'b1));
      chk({tag, "_rd_vld"}, v_t'(rd_vld), v_t'(1'b0));
      chk({tag, "_rd_data"}, v_t'(rd_data), v_t'(0));
      chk({tag, "_flags"}, v_t'({rd_serr, rd_derr}), v_t'(0));
      chk({tag, "_cnt"}, v_t'(fifo_cnt), v_t'(0));
      chk({tag, "_strb"}, v_t'({ram_csa, ram_wea, ram_csb, ram_reb}), v_t'(0));
      chk({tag, "_addr"}, v_t'({ram_aa, ram_ab}), v_t'(0));
      chk({tag, "_da"}, v_t'(ram_da), v_t'(0));
   endtask

   int i0, p0, n;
   logic [15:0] exp_ecnt;

   initial begin
      rst_n = 1'b0; wr_vld = 1'b0; wr_data = '0; rd_rdy = 1'b0; err_clr = 1'b0; err_en = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk_reset_outs("rst");
      chk("rst_ecnt", v_t'({serr_cnt, derr_cnt}), v_t'(0));
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // single word latency
      wr_vld = 1'b1; rd_rdy = 1'b1;
      wr_data = {{17{8'h5A}}, 4'h5};
      @(negedge clk);
      chk("t0_wstrb", v_t'({ram_csa, ram_wea}), v_t'(2'b11));
      chk("t0_aa", v_t'(ram_aa), v_t'(0));
      chk("t0_da", v_t'(ram_da), v_t'({{17{8'h5A}}, 4'h5}));
      chk("t0_cnt", v_t'(fifo_cnt), v_t'(0));
      @(posedge clk);
      #1;
      wr_vld = 1'b0;
      @(negedge clk);
      chk("t1_rstrb", v_t'({ram_csb, ram_reb}), v_t'(2'b11));
      chk("t1_ab", v_t'(ram_ab), v_t'(0));
      chk("t1_cnt", v_t'(fifo_cnt), v_t'(1));
      @(negedge clk);
      chk("t2_vld", v_t'({rd_vld, ram_csb}), v_t'(0));
      chk("t2_cnt", v_t'(fifo_cnt), v_t'(1));
      @(negedge clk);
      chk("t3_vld", v_t'(rd_vld), v_t'(0));
      chk("t3_cnt", v_t'(fifo_cnt), v_t'(1));
      @(negedge clk);
      chk("t4_vld", v_t'(rd_vld), v_t'(1));
      chk("t4_data", v_t'(rd_data), v_t'({{17{8'h5A}}, 4'h5}));
      chk("t4_cnt", v_t'(fifo_cnt), v_t'(1));
      @(negedge clk);
      chk("t5_vld", v_t'(rd_vld), v_t'(0));
      chk("t5_cnt", v_t'(fifo_cnt), v_t'(0));
      @(posedge clk);
      #1;

      // fill to full with consumer stalled
      wr_data = pat(wseq);
      rd_rdy = 1'b0; wr_vld = 1'b1;
      i0 = iss_total;
      n = 0;
      while (wr_rdy && n < 80) begin
         tick();
         n++;
      end
      chk("fill_wr_rdy", v_t'(wr_rdy), v_t'(1'b0));
      chk("fill_cnt", v_t'(fifo_cnt), v_t'(36));
      chk("fill_words", v_t'(exp_q.size()), v_t'(36));
      repeat (3) tick();
      chk("full_wr_rdy", v_t'(wr_rdy), v_t'(1'b0));
      chk("full_cnt", v_t'(fifo_cnt), v_t'(36));
      chk("fill_issues", v_t'(iss_total - i0), v_t'(4));
      drain("fill_drain");
      chk("post_fill_wr_rdy", v_t'(wr_rdy), v_t'(1'b1));

      // sustained streaming
      p0 = pops;
      wr_vld = 1'b1; rd_rdy = 1'b1;
      repeat (200) tick();
      chk("stream_pops", v_t'(pops - p0), v_t'(196));
      drain("stream_drain");

      // random consumer stalls
      wr_vld = 1'b1;
      repeat (100) begin
         rd_rdy = 1'($urandom_range(0, 1));
         tick();
      end
      drain("stall_drain");

      // ECC flag delivery and counters
      err_en = 1'b1;
      do_reset();
      p0 = pops;
      wr_vld = 1'b1; rd_rdy = 1'b1;
      repeat (10) tick();
      drain("ecc_drain");
      chk("ecc_pops", v_t'(pops - p0), v_t'(10));
`ifdef FIFO_ECC_ERR_CNT_EN
      exp_ecnt = 16'd1;
`else
      exp_ecnt = 16'd0;
`endif
      chk("serr_cnt", v_t'(serr_cnt), v_t'(exp_ecnt));
      chk("derr_cnt", v_t'(derr_cnt), v_t'(exp_ecnt));
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      chk("clr_ecnt", v_t'({serr_cnt, derr_cnt}), v_t'(0));
      err_en = 1'b0;

      // reset mid-operation
      wr_vld = 1'b1; rd_rdy = 1'b0;
      repeat (5) tick();
      chk("mid_cnt", v_t'(fifo_cnt), v_t'(5));
      wr_vld = 1'b0;
      rst_n = 1'b0;
      #1;
      chk_reset_outs("mid_rst");
      tick();
      rst_n = 1'b1;
      repeat (6) begin
         tick();
         chk("stale_vld", v_t'(rd_vld), v_t'(1'b0));
         chk("stale_cnt", v_t'(fifo_cnt), v_t'(0));
      end
      p0 = pops;
      wr_vld = 1'b1;
      tick();
      drain("post_rst_drain");
      chk("post_rst_pops", v_t'(pops - p0), v_t'(1));

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not reach the end");
      $fatal(1);
   end

endmodule

// File: doc/sync_fifo_ram_rd_ctrl.md
Name: sync_fifo_ram_rd_ctrl

Overview:
- Single-clock FIFO controller that drives a two-port ECC RAM wrapper.
- Write side: issues write strobes and addresses into the wrapper.
- Read side: prefetches words through the wrapper's 2-cycle read pipeline into a small output buffer, then presents them on a valid/ready interface with per-word ECC single/double error flags.
- Sits between a producer/consumer pair and one RAMxxXyyy_WRAPPER instance with both wrapper clocks tied to clk.

Parameters:
- ADDR_WIDTH, 5, RAM address width; DEPTH = 1<<ADDR_WIDTH; must be >= 2.
- DATA_WIDTH, 140, user data width; matches wrapper DATA_WIDTH.
- RD_LATENCY, 2, cycles from ram_csb/ram_reb asserted to ram_qb/ram_serr/ram_derr valid.
- BUF_DEPTH, 4, output buffer entries; must be >= RD_LATENCY+1.

Ports:
- clk  in  1  single clock; also drives both wrapper clocks.
- rst_n  in  1  asynchronous active-low reset.
- wr_vld  in  1  producer write request.
- wr_rdy  out  1  controller can accept a write.
- wr_data  in  DATA_WIDTH  write data.
- rd_vld  out  1  output buffer head is valid.
- rd_rdy  in  1  consumer accepts the head.
- rd_data  out  DATA_WIDTH  head data.
- rd_serr  out  1  head word had a corrected single-bit error.
- rd_derr  out  1  head word had an uncorrectable double-bit error.
- fifo_cnt  out  ADDR_WIDTH+2  total words held (RAM + in flight + buffer).
- ram_csa, ram_wea  out  1  wrapper port A chip select and write enable, active high.
- ram_aa  out  ADDR_WIDTH  port A address.
- ram_da  out  DATA_WIDTH  port A data.
- ram_csb, ram_reb  out  1  wrapper port B chip select and read enable, active high.
- ram_ab  out  ADDR_WIDTH  port B address.
- ram_qb  in  DATA_WIDTH  wrapper read data.
- ram_serr, ram_derr  in  1  wrapper error flags, aligned with ram_qb.
- err_clr  in  1  clears the error counters.
- serr_cnt, derr_cnt  out  16  error counters (see Optional Feature).

Behaviour:
- Reset: wptr, rptr, mem_cnt, inflight and buf_cnt clear to 0.
  - Outputs after reset: wr_rdy=1, rd_vld=0, rd_data=0, rd_serr=0, rd_derr=0, fifo_cnt=0.
  - RAM outputs after reset: all strobes 0, addresses 0, ram_da=0.
  - Reset mid-operation discards all contents; any wrapper returns still in flight are ignored.
- Write path:
  - wr_rdy = (mem_cnt < DEPTH).
  - On wr_vld&wr_rdy, in the same cycle (combinational): ram_csa=ram_wea=1, ram_aa=wptr, ram_da=wr_data.
  - wptr increments and wraps at DEPTH; mem_cnt increments at the next edge.
- Read issue:
  - Issue when mem_cnt>0 and (inflight+buf_cnt) < BUF_DEPTH.
  - On issue: ram_csb=ram_reb=1, ram_ab=rptr; rptr wraps; mem_cnt decrements.
  - Because mem_cnt is registered, a written word is readable one cycle after its write. ram_ab therefore never equals ram_aa on a live write, so no same-address collision occurs.
- Return capture:
  - A shift register of RD_LATENCY valid bits tracks issued reads.
  - When the last stage is 1, {ram_qb, ram_serr, ram_derr} is pushed into the output buffer.
  - The buffer never overflows, guaranteed by the issue credit check.
  - inflight = popcount of the shift register.
- Output:
  - rd_vld = (buf_cnt>0).
  - The head is registered buffer storage; rd_data/rd_serr/rd_derr stay stable while rd_vld&!rd_rdy.
  - A pop occurs on rd_vld&rd_rdy.
  - A push and a pop in the same cycle leave buf_cnt unchanged.
- Latency:
  - Empty FIFO, write at cycle t: read issue at t+1, return at t+1+RD_LATENCY, rd_vld at t+2+RD_LATENCY (t+4 with defaults).
  - Sustained throughput is 1 word/cycle once primed.
- Counting and boundaries:
  - fifo_cnt = mem_cnt + inflight + buf_cnt; maximum DEPTH+BUF_DEPTH.
  - A write and a read issue in the same cycle leave mem_cnt unchanged.
  - A write in the same cycle the FIFO becomes not-full is accepted only from the next cycle, since wr_rdy is computed from registered mem_cnt.
  - Pointer wrap from DEPTH-1 to 0 is seamless.
  - Error flags pass per word and are never sticky.
  - A double-error word is still delivered; the consumer decides what to do with it.

Optional Feature:
- Macro: FIFO_ECC_ERR_CNT_EN.
- With the macro defined:
  - serr_cnt and derr_cnt increment by 1 when a word with the corresponding flag pops (rd_vld&rd_rdy).
  - Both counters saturate at 16'hFFFF.
  - err_clr synchronously zeroes both counters and takes priority over a same-cycle increment.
  - Reset value is 0.
- Without the macro: serr_cnt=derr_cnt=0 constant, err_clr is ignored, and no counter flops exist.

Test Plan:
- Reset then 1 write of 0x5A..5A with rd_rdy=1 -> ram_csa/ram_wea=1 with ram_aa=0 at t; ram_csb/ram_reb=1 with ram_ab=0 at t+1; rd_vld=1 with rd_data=0x5A..5A at t+4; fifo_cnt goes 0,1,...,1,0.
- rd_rdy=0, write 36 words -> wr_rdy drops after fifo_cnt=36 (32 in RAM + 4 in buffer), at most 4 reads ever issued; then rd_rdy=1 -> all 36 words out in order, pointers wrap cleanly.
- Continuous wr_vld and rd_rdy for 200 cycles with an incrementing pattern -> 1 word/cycle after the fill latency, no gaps, no drops, data matches the sequence.
- Random rd_rdy stalls at 50% -> rd_data/rd_serr/rd_derr hold stable while stalled, order preserved, buffer never exceeds 4.
- Wrapper model flags ram_serr on the 3rd returned word and ram_derr on the 7th -> rd_serr/rd_derr are set only on those words; with FIFO_ECC_ERR_CNT_EN, serr_cnt=1 and derr_cnt=1; err_clr=1 -> both 0.
- Assert rst_n low with 5 words in flight/buffered -> all outputs return to reset values immediately; stale wrapper returns after release do not appear on rd_vld.
